svc_rv_mem_arbiter: RTL and testbench



---
 rtl/svc_rv_mem_arb_pkg.sv | 22 ++
 rtl/svc_rv_mem_arb_pick.sv | 68 ++++++
 rtl/svc_rv_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_svc_rv_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_mem_arb_pkg.sv
// svc_rv_mem_arb_pkg
// Shared types and helpers for the svc_rv unified-memory arbiter.
//   owner_t            : tag recording which port owns the read response in flight
//   starve_cnt_width() : bit width needed to count 0..starve_max
package svc_rv_mem_arb_pkg;

  // Owner of the SRAM read issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  // Legal range of the starvation bound.
  localparam int unsigned STARVE_MAX_MIN = 1;
  localparam int unsigned STARVE_MAX_LIM = 15;

  function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/svc_rv_mem_arb_pick.sv
// svc_rv_mem_arb_pick
// Grant selection between the fetch (imem) and data (dmem) ports plus the
// starvation counter that bounds how long fetch can be held off by data.
// Ports:
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_imem_req, i_dmem_req   : requests from the two ports
//   o_imem_gnt, o_dmem_gnt   : one-hot-or-zero grants, combinational
module svc_rv_mem_arb_pick
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_imem_req,
  input  logic i_dmem_req,
  output logic o_imem_gnt,
  output logic o_dmem_gnt
);

  localparam int unsigned SW = starve_cnt_width(STARVE_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_cnt_next;
  logic          w_imem_turn;

  // Fetch takes the slot once data has won STARVE_MAX times in a row over it.
  assign w_imem_turn = (r_starve_cnt == SMAX);

  // Grants are forced low while reset is asserted.
  always_comb begin
    o_imem_gnt = 1'b0;
    o_dmem_gnt = 1'b0;
    if (i_rst_n) begin
      if (i_imem_req && i_dmem_req) begin
        if (w_imem_turn) begin
          o_imem_gnt = 1'b1;
        end else begin
          o_dmem_gnt = 1'b1;
        end
      end else if (i_imem_req) begin
        o_imem_gnt = 1'b1;
      end else if (i_dmem_req) begin
        o_dmem_gnt = 1'b1;
      end
    end
  end

  // Counts consecutive data wins while fetch is waiting; saturates at SMAX.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (o_imem_gnt || !i_imem_req) begin
      w_starve_cnt_next = '0;
    end else if (o_dmem_gnt && (r_starve_cnt != SMAX)) begin
      w_starve_cnt_next = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

endmodule

// File: rtl/svc_rv_mem_arbiter.sv
// svc_rv_mem_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// svc_rv instruction-fetch port and the data port. At most one request is
// granted per cycle; read data is routed back to its owner the next cycle.
// Optional build macro: SVC_RV_MEM_ARB_STATS_EN adds conflict / fetch-wait
// counters as extra output ports.
// Ports:
//   i_clk, i_rst_n                        : clock, synchronous active-low reset
//   i_imem_req/addr, o_imem_gnt           : fetch request side
//   o_imem_rvalid/rdata                   : fetch response
//   i_dmem_req/we/addr/wdata/wstrb        : data request side
//   o_dmem_gnt, o_dmem_rvalid/rdata       : data grant and response
//   o_mem_ren/raddr, i_mem_rdata          : SRAM read port
//   o_mem_we/waddr/wdata/wstrb            : SRAM write port
//   o_stat_conflicts, o_stat_imem_wait    : wrapping statistics (macro only)
module svc_rv_mem_arbiter
  import svc_rv_mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  // Fetch port
  input  logic            i_imem_req,
  input  logic [AW-1:0]   i_imem_addr,
  output logic            o_imem_gnt,
  output logic            o_imem_rvalid,
  output logic [DW-1:0]   o_imem_rdata,
  // Data port
  input  logic            i_dmem_req,
  input  logic            i_dmem_we,
  input  logic [AW-1:0]   i_dmem_addr,
  input  logic [DW-1:0]   i_dmem_wdata,
  input  logic [DW/8-1:0] i_dmem_wstrb,
  output logic            o_dmem_gnt,
  output logic            o_dmem_rvalid,
  output logic [DW-1:0]   o_dmem_rdata,
  // SRAM side
  output logic            o_mem_ren,
  output logic [AW-1:0]   o_mem_raddr,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_waddr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wstrb
`ifdef SVC_RV_MEM_ARB_STATS_EN
  ,
  output logic [31:0]     o_stat_conflicts,
  output logic [31:0]     o_stat_imem_wait
`endif
);

  logic   w_imem_gnt;
  logic   w_dmem_gnt;
  owner_t r_owner;
  owner_t w_owner_next;

  svc_rv_mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_imem_req (i_imem_req),
    .i_dmem_req (i_dmem_req),
    .o_imem_gnt (w_imem_gnt),
    .o_dmem_gnt (w_dmem_gnt)
  );

  assign o_imem_gnt = w_imem_gnt;
  assign o_dmem_gnt = w_dmem_gnt;

  // SRAM request mux; everything is zero when nothing is granted.
  always_comb begin
    o_mem_ren   = 1'b0;
    o_mem_raddr = '0;
    o_mem_we    = 1'b0;
    o_mem_waddr = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    if (w_imem_gnt) begin
      o_mem_ren   = 1'b1;
      o_mem_raddr = i_imem_addr;
    end else if (w_dmem_gnt) begin
      if (i_dmem_we) begin
        o_mem_we    = 1'b1;
        o_mem_waddr = i_dmem_addr;
        o_mem_wdata = i_dmem_wdata;
        o_mem_wstrb = i_dmem_wstrb;
      end else begin
        o_mem_ren   = 1'b1;
        o_mem_raddr = i_dmem_addr;
      end
    end
  end

  // Owner of the read issued this cycle; writes and idle cycles leave no owner.
  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_imem_gnt) begin
      w_owner_next = OWN_IMEM;
    end else if (w_dmem_gnt && !i_dmem_we) begin
      w_owner_next = OWN_DMEM;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Gating with reset drops a response whose grant was followed by reset.
  assign o_imem_rvalid = i_rst_n && (r_owner == OWN_IMEM);
  assign o_dmem_rvalid = i_rst_n && (r_owner == OWN_DMEM);
  assign o_imem_rdata  = i_mem_rdata;
  assign o_dmem_rdata  = i_mem_rdata;

`ifdef SVC_RV_MEM_ARB_STATS_EN
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_imem_wait;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stat_conflicts <= '0;
      r_stat_imem_wait <= '0;
    end else begin
      if (i_imem_req && i_dmem_req) begin
        r_stat_conflicts <= r_stat_conflicts + 32'd1;
      end
      if (i_imem_req && !w_imem_gnt) begin
        r_stat_imem_wait <= r_stat_imem_wait + 32'd1;
      end
    end
  end

  assign o_stat_conflicts = r_stat_conflicts;
  assign o_stat_imem_wait = r_stat_imem_wait;
`endif

endmodule

// File: tb/tb_svc_rv_mem_arbiter.sv
// tb_svc_rv_mem_arbiter
// Directed scenarios followed by randomized traffic. The stimulus task predicts
// grants and SRAM-side outputs from the arbitration rules and queues expected
// read responses; a forked monitor pops and compares them when rvalid appears.
module tb_svc_rv_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic          mem_ren;
  logic [31:0]   mem_raddr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_we;
  logic [31:0]   mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
`ifdef SVC_RV_MEM_ARB_STATS_EN
  logic [31:0]   stat_conflicts;
  logic [31:0]   stat_imem_wait;
`endif

  always #5 clk = ~clk;

  svc_rv_mem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (SM)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_imem_req    (imem_req),
    .i_imem_addr   (imem_addr),
    .o_imem_gnt    (imem_gnt),
    .o_imem_rvalid (imem_rvalid),
    .o_imem_rdata  (imem_rdata),
    .i_dmem_req    (dmem_req),
    .i_dmem_we     (dmem_we),
    .i_dmem_addr   (dmem_addr),
    .i_dmem_wdata  (dmem_wdata),
    .i_dmem_wstrb  (dmem_wstrb),
    .o_dmem_gnt    (dmem_gnt),
    .o_dmem_rvalid (dmem_rvalid),
    .o_dmem_rdata  (dmem_rdata),
    .o_mem_ren     (mem_ren),
    .o_mem_raddr   (mem_raddr),
    .i_mem_rdata   (mem_rdata),
    .o_mem_we      (mem_we),
    .o_mem_waddr   (mem_waddr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_wstrb   (mem_wstrb)
`ifdef SVC_RV_MEM_ARB_STATS_EN
    ,
    .o_stat_conflicts (stat_conflicts),
    .o_stat_imem_wait (stat_imem_wait)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // SRAM environment model: 256 words, 1-cycle read latency.
  logic [31:0] sram [256];
  bit          sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      sram_init <= 1'b1;
    end else begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) sram[mem_waddr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      if (mem_ren) mem_rdata <= sram[mem_raddr[9:2]];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        q_i[$];
  exp_t        q_d[$];
  logic [31:0] ref_mem [256];
  int          starve = 0;
  int unsigned m_conf = 0;
  int unsigned m_wait = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic due;
    forever begin
      @(posedge clk);
      #3;
      due = (q_i.size() != 0) && (q_i[0].cyc + 1 == cyc);
      chk("imem_rvalid", 32'(imem_rvalid), 32'(due));
      if (due) begin
        e = q_i.pop_front();
        if (imem_rvalid) chk("imem_rdata", imem_rdata, e.data);
      end
      due = (q_d.size() != 0) && (q_d[0].cyc + 1 == cyc);
      chk("dmem_rvalid", 32'(dmem_rvalid), 32'(due));
      if (due) begin
        e = q_d.pop_front();
        if (dmem_rvalid) begin
          chk("dmem_rdata", dmem_rdata, e.data);
          last_d = dmem_rdata;
        end
      end
    end
  endtask

  // One clock cycle: drive, predict from the arbitration rules, compare, update model.
  task automatic step(input logic rv, input logic ir, input logic [31:0] ia, input logic dr,
                      input logic dw, input logic [31:0] da, input logic [31:0] wd,
                      input logic [3:0] ws, output logic ig, output logic dg);
    logic ei, ed, eren, ewe;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rv; imem_req = ir; imem_addr = ia; dmem_req = dr; dmem_we = dw;
    dmem_addr = da; dmem_wdata = wd; dmem_wstrb = ws;
    if (!rv) begin
      q_i.delete();
      q_d.delete();
    end
    #4;
    ei = 1'b0;
    ed = 1'b0;
    if (rv) begin
      if (ir && dr) begin
        if (starve == int'(SM)) ei = 1'b1;
        else ed = 1'b1;
      end else begin
        ei = ir;
        ed = dr;
      end
    end
    eren = ei || (ed && !dw);
    ewe  = ed && dw;
    chk("imem_gnt", 32'(imem_gnt), 32'(ei));
    chk("dmem_gnt", 32'(dmem_gnt), 32'(ed));
    chk("mem_ren", 32'(mem_ren), 32'(eren));
    chk("mem_raddr", mem_raddr, ei ? ia : (eren ? da : 32'h0));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_waddr", mem_waddr, ewe ? da : 32'h0);
    chk("mem_wdata", mem_wdata, ewe ? wd : 32'h0);
    chk("mem_wstrb", 32'(mem_wstrb), ewe ? 32'(ws) : 32'h0);
    e.cyc = cyc;
    if (ei) begin
      e.data = ref_mem[ia[9:2]];
      q_i.push_back(e);
    end
    if (ed && !dw) begin
      e.data = ref_mem[da[9:2]];
      q_d.push_back(e);
    end
    if (ewe) begin
      for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[da[9:2]][8*b +: 8] = wd[8*b +: 8];
    end
    if (!rv) begin
      starve = 0;
      m_conf = 0;
      m_wait = 0;
    end else begin
      if (ei || !ir) starve = 0;
      else if (ed && starve < int'(SM)) starve = starve + 1;
      if (ir && dr) m_conf++;
      if (ir && !ei) m_wait++;
    end
    ig = ei;
    dg = ed;
  endtask

  task automatic idle(input int n);
    logic ig, dg;
    repeat (n) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ig, dg);
  endtask

  initial begin
    logic        ig, dg;
    logic [9:0]  pat;
    logic [4:0]  pat5;
    logic [31:0] ia, da;
    logic        ir, dr, dw;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        rv;

    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_we = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    fork
      monitor();
    join_none

    // Reset
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ig, dg);

    // Fetch-only stream 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ig, dg);
      chk("t1_imem_gnt", 32'(ig), 32'h1);
    end
    idle(2);

    // Both ports hammering reads for 10 cycles after a fresh reset
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ig, dg);
    ia = 32'h40;
    da = 32'h80;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 4'h0, ig, dg);
      pat[k] = ig;
      if (ig) ia = ia + 32'h4;
      if (dg) da = da + 32'h4;
    end
    chk("t2_grant_pattern", 32'(pat), 32'h210);
    idle(2);
`ifdef SVC_RV_MEM_ARB_STATS_EN
    chk("t5_stat_conflicts", stat_conflicts, 32'd10);
    chk("t5_stat_imem_wait", stat_imem_wait, 32'd8);
`endif

    // Partial write then read back
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'b0011, ig, dg);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, ig, dg);
    idle(2);
    chk("t3_rdata", last_d, 32'h0000_A5A5);

    // Build starvation, grant a read, then reset the next cycle
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, ig, dg);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0, ig, dg);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h208, 32'h0, 4'h0, ig, dg);
    chk("t4_gnt_in_reset", 32'({imem_gnt, dmem_gnt, mem_ren, mem_we}), 32'h0);
    ia = 32'h100;
    da = 32'h208;
    pat5 = '0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, ia, 1'b1, 1'b0, da, 32'h0, 4'h0, ig, dg);
      pat5[k] = ig;
      if (ig) ia = ia + 32'h4;
      if (dg) da = da + 32'h4;
    end
    chk("t4_starve_cleared", 32'(pat5), 32'h10);
    idle(2);

    // Randomized traffic; requesters hold until granted
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; wd = '0; ws = '0;
    for (int k = 0; k < 400; k++) begin
      if (!ir && ($urandom_range(0, 9) < 6)) begin
        ir = 1'b1;
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!dr && ($urandom_range(0, 9) < 6)) begin
        dr = 1'b1;
        dw = 1'($urandom_range(0, 1));
        da = 32'($urandom_range(0, 255)) << 2;
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
      end
      rv = ($urandom_range(0, 49) != 0);
      step(rv, ir, ia, dr, dw, da, wd, ws, ig, dg);
      if (ig) ir = 1'b0;
      if (dg) dr = 1'b0;
    end
    idle(3);
    chk("queues_drained", 32'(q_i.size() + q_d.size()), 32'h0);
`ifdef SVC_RV_MEM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, m_conf);
    chk("stat_imem_wait", stat_imem_wait, m_wait);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
